// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock,
// LSB first, using a single full-subtractor cell and a registered borrow.
// Trades latency (WIDTH+2 cycles per result) for area.
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; operands captured on the accepting edge
//   ST_RUN   | one operand bit pair consumed per clock, borrow carried over
//   ST_DONE  | one-cycle done pulse; Diff/Bout hold the new result
//
// Ports
//   clk    in   clock, all state updates on rising edge
//   rst    in   synchronous active-high reset (highest priority)
//   start  in   request a new subtraction, accepted only in ST_IDLE
//   A      in   minuend, sampled on the accepting edge
//   B      in   subtrahend, sampled on the accepting edge
//   Bin    in   borrow-in, sampled on the accepting edge
//   busy   out  high while bits are being processed (ST_RUN)
//   done   out  one-cycle pulse, Diff/Bout valid
//   Diff   out  registered difference, updated only on completion
//   Bout   out  registered final borrow-out
// -----------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic             bit_a, bit_b, bit_br;
  logic             bit_d, bit_bnext;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    bit_a     = opa_q[0];
    bit_b     = opb_q[0];
    bit_br    = borrow_q;
    bit_d     = bit_a ^ bit_b ^ bit_br;
    bit_bnext = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bit_br);
  end

  // New bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lands in natural bit order. Written this way to stay legal
  // for WIDTH=1 where there is no res_q[WIDTH-1:1] slice.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = bit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d    = A;
          opb_d    = B;
          borrow_d = Bin;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        borrow_d = bit_bnext;
        res_d    = res_shift;
        cnt_d    = cnt_q + CW'(1);
        // Result registers see this edge's bit directly, not res_q.
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_shift;
          bout_d  = bit_bnext;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here; only IDLE accepts requests.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .A    (a8),
    .B    (b8),
    .Bin  (bin8),
    .busy (busy8),
    .done (done8),
    .Diff (diff8),
    .Bout (bout8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .A    (a1),
    .B    (b1),
    .Bin  (bin1),
    .busy (busy1),
    .done (done1),
    .Diff (diff1),
    .Bout (bout1)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic, not a bit-serial loop.
  function automatic logic [7:0] ref_diff8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return 8'(r & 255);
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  // Full WIDTH=8 operation with cycle-exact busy/done checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input string tag);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      chk({tag, " busy/done in RUN"}, {busy8, done8}, 2'b10);
      @(negedge clk);
    end
    chk({tag, " busy/done at done"}, {busy8, done8}, 2'b01);
    chk({tag, " Diff"}, diff8, ed);
    chk({tag, " Bout"}, bout8, eb);
    @(negedge clk);
    chk({tag, " done single pulse"}, {busy8, done8}, 2'b00);
    chk({tag, " Diff hold"}, diff8, ed);
  endtask

  task automatic op1(input logic a, input logic b, input logic bin,
                     input logic ed, input logic eb, input string tag);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
    chk({tag, " w1 busy/done in RUN"}, {busy1, done1}, 2'b10);
    @(negedge clk);
    chk({tag, " w1 busy/done at done"}, {busy1, done1}, 2'b01);
    chk({tag, " w1 Diff"}, diff1, ed);
    chk({tag, " w1 Bout"}, bout1, eb);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic d;
    logic bo;
  } vec1_t;

  vec8_t v8[6];
  vec1_t v1[8];

  initial begin
    int dones;

    v8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    v8[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    v8[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    v8[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    v8[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    v8[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};

    // Full-subtractor truth table {a,b,bin} -> {d,bout}.
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset w8 busy/done", {busy8, done8}, 2'b00);
    chk("reset w8 Diff", diff8, 8'h00);
    chk("reset w8 Bout", bout8, 1'b0);
    chk("reset w1 busy/done", {busy1, done1}, 2'b00);
    chk("reset w1 Diff/Bout", {diff1, bout1}, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      op8(v8[i].a, v8[i].b, v8[i].bin, v8[i].d, v8[i].bo, $sformatf("vec8[%0d]", i));

    // start pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      if (done8) dones++;
      chk("midrun busy", busy8, (i <= 8) ? 1 : 0);
      if (i == 9) begin
        chk("midrun Diff", diff8, 8'h7F);
        chk("midrun Bout", bout8, 1'b0);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("midrun done count", dones, 1);

    // Reset in RUN discards the partial operation and clears the outputs.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst midrun busy/done", {busy8, done8}, 2'b00);
    chk("rst midrun Diff", diff8, 8'h00);
    chk("rst midrun Bout", bout8, 1'b0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done8 || busy8) dones++;
      @(negedge clk);
    end
    chk("rst midrun stays idle", dones, 0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "after rst");

    // start held high: a result every 10 cycles, Diff stable in between.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 40; i++) begin
      chk($sformatf("held start done c%0d", i), done8, (i % 10 == 9) ? 1 : 0);
      chk($sformatf("held start busy c%0d", i), busy8, (i % 10 != 9 && i % 10 != 0) ? 1 : 0);
      chk($sformatf("held start Diff c%0d", i), diff8, (i < 9) ? 8'hFE : 8'h05);
      if (i == 40) start8 = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra, rb;
      logic rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (n % 10 == 0) ra = rb;
      op8(ra, rb, rbin, ref_diff8(ra, rb, rbin), ref_bout(int'(ra), int'(rb), int'(rbin)),
          $sformatf("rand[%0d] %0h-%0h-%0b", n, ra, rb, rbin));
    end

    for (int i = 0; i < 8; i++)
      op1(v1[i].a, v1[i].b, v1[i].bin, v1[i].d, v1[i].bo, $sformatf("tt[%0d]", i));

    for (int n = 0; n < 24; n++) begin
      logic ra, rb, rbin;
      int r;
      ra = 1'($urandom); rb = 1'($urandom); rbin = 1'($urandom);
      r = int'(ra) - int'(rb) - int'(rbin);
      op1(ra, rb, rbin, 1'(r & 1), ref_bout(int'(ra), int'(rb), int'(rbin)),
          $sformatf("rand1[%0d]", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
